disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000, number of clk cycles each digit is driven (legal range 1..65535).
REQ-002 Parameter BLANK, default 16, number of clk cycles of anti-ghosting blank between digits (legal range 1..255).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = scan display, 0 = stop scanning.
REQ-006 seg0, seg1, seg2, seg3  input  12 each  segment patterns for digits 0..3.
REQ-007 dig_en  input  4  per-digit enable mask; bit i = digit i participates.
REQ-008 load  input  1  single-cycle pulse; captures seg0..seg3 and dig_en into the pending buffer.
REQ-009 seg_out  output  12  segment pattern on the shared display bus.
REQ-010 dig_sel  output  4  one-hot digit select, all-zero when no digit is driven.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-012 load_ack  output  1  one-cycle pulse when pending data becomes active.

Function
REQ-013 The block SHALL hold three register sets: pending (4x12 patterns + mask + pending flag), active (4x12 patterns + mask), and scan state.
REQ-014 The FSM SHALL have states IDLE, DRIVE, BLANK; all outputs SHALL be registered.
REQ-015 IDLE: seg_out=0, dig_sel=0; scan index = 0.
REQ-016 In IDLE, if the pending flag is set, the pending buffer SHALL be copied to active on the next edge, the flag cleared, and load_ack pulsed for that one cycle.
REQ-017 IDLE -> DRIVE when enable=1 and the active mask is nonzero; the lowest enabled index is driven starting in the cycle after enable is sampled.
REQ-018 With enable=1 and active mask = 0, the block SHALL remain in IDLE.
REQ-019 DRIVE: seg_out = active pattern[idx], dig_sel = one-hot(idx), for exactly DIV cycles, then BLANK.
REQ-020 BLANK: seg_out=0, dig_sel=0 for exactly BLANK cycles.
REQ-021 At the end of BLANK with enable=1, idx SHALL advance to the next enabled index above idx, wrapping to the lowest enabled index; disabled digits SHALL consume no cycles.
REQ-022 A wrap (leaving the highest enabled index) is a frame boundary: frame_done SHALL pulse in the first DRIVE cycle of the new frame.
REQ-023 At a frame boundary with the pending flag set, pending SHALL be copied to active on the same edge, so the new frame's first DRIVE already uses the new patterns and mask; load_ack SHALL pulse together with frame_done.
REQ-024 If the newly applied mask is zero, the block SHALL go to IDLE instead of DRIVE, with frame_done still pulsed.
REQ-025 load=1 SHALL overwrite pending and set the flag in any state; a load in the same cycle as an apply SHALL be kept pending for the next boundary, and the previous pending contents SHALL be applied.
REQ-026 enable=0 sampled in DRIVE SHALL force BLANK on the next edge; after BLANK completes (enable=0), the block SHALL enter IDLE; frame_done SHALL NOT pulse.
REQ-027 Frame period = (number of enabled digits) x (DIV + BLANK) cycles.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with seg_out=0, dig_sel=0, frame_done=0, load_ack=0, idx=0, counters=0, pending and active registers and pending flag = 0; outputs SHALL clear immediately without waiting for clk.
REQ-029 After rst_n rises, the first state change SHALL occur on the first clk edge.

Verification (DIV=4, BLANK=2)
REQ-030 Reset; in IDLE, load seg0..3=0x001,0x002,0x004,0x008 with dig_en=1111 -> load_ack one cycle later; then enable=1 -> dig_sel 0001/seg_out 0x001 for 4 cycles, 0 for 2, then 0010/0x002, and so on; frame_done every 24 cycles.
REQ-031 dig_en=1010 applied -> only 0010 and 1000 are driven; frame_done period = 12 cycles; no idle gap for digits 0 and 2.
REQ-032 Load 0xFFF on all digits during digit 1 DRIVE -> digits 2 and 3 still show old values; the new frame starts with 0xFFF; load_ack coincides with frame_done.
REQ-033 enable=0 during digit 2 DRIVE -> next cycle is BLANK for 2 cycles, then IDLE with outputs 0; enable=1 again -> restarts at the lowest enabled digit.
REQ-034 rst_n=0 mid-DRIVE -> seg_out and dig_sel are 0 before the next clk edge; after release with enable=1, the block stays in IDLE (active mask = 0).
REQ-035 load of dig_en=0000 at a boundary -> frame_done and load_ack pulse, then IDLE, outputs 0.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit display scanner with double-buffered patterns.
// Pending data is applied in IDLE or at a frame boundary only.
module disp_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] seg0,
    input  logic [11:0] seg1,
    input  logic [11:0] seg2,
    input  logic [11:0] seg3,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic [11:0] seg_out,
    output logic [3:0]  dig_sel,
    output logic        frame_done,
    output logic        load_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_BLANK} state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLANK - 1);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [15:0] cnt, cnt_n;
    logic [11:0] pend_seg [4];
    logic [11:0] pend_seg_n [4];
    logic [11:0] act_seg [4];
    logic [11:0] act_seg_n [4];
    logic [3:0]  pend_mask, pend_mask_n;
    logic [3:0]  act_mask, act_mask_n;
    logic        pend_flag, pend_flag_n;
    logic [11:0] seg_n;
    logic [3:0]  sel_n;
    logic        frame_n, ack_n;
    logic        apply;
    logic [3:0]  new_mask;
    logic [2:0]  up;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    // {found, index} of the next enabled digit strictly above cur
    function automatic logic [2:0] next_up(input logic [3:0] m,
                                           input logic [1:0] cur);
        next_up = 3'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i] && i > int'(cur)) next_up = {1'b1, 2'(i)};
    endfunction

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        pend_seg_n  = pend_seg;
        pend_mask_n = pend_mask;
        pend_flag_n = pend_flag;
        act_seg_n   = act_seg;
        act_mask_n  = act_mask;
        frame_n     = 1'b0;
        ack_n       = 1'b0;
        seg_n       = 12'd0;
        sel_n       = 4'd0;
        apply       = 1'b0;
        new_mask    = act_mask;
        up          = next_up(act_mask, idx);
        unique case (state)
            ST_IDLE: begin
                idx_n = 2'd0;
                cnt_n = 16'd0;
                if (pend_flag) begin
                    apply = 1'b1;
                end else if (enable && act_mask != 4'd0) begin
                    state_n = ST_DRIVE;
                    idx_n   = lowest(act_mask);
                end
            end
            ST_DRIVE: begin
                if (!enable || cnt == DIV_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_BLANK: begin
                if (cnt != BLK_LAST) begin
                    cnt_n = cnt + 16'd1;
                end else begin
                    cnt_n = 16'd0;
                    if (!enable) begin
                        state_n = ST_IDLE;
                        idx_n   = 2'd0;
                    end else if (up[2]) begin
                        state_n = ST_DRIVE;
                        idx_n   = up[1:0];
                    end else begin
                        // wrap: frame boundary, swap in pending data
                        frame_n  = 1'b1;
                        apply    = pend_flag;
                        new_mask = pend_flag ? pend_mask : act_mask;
                        state_n  = (new_mask != 4'd0) ? ST_DRIVE : ST_IDLE;
                        idx_n    = lowest(new_mask);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (apply) begin
            act_seg_n   = pend_seg;
            act_mask_n  = pend_mask;
            pend_flag_n = 1'b0;
            ack_n       = 1'b1;
        end
        if (load) begin
            pend_seg_n  = '{seg0, seg1, seg2, seg3};
            pend_mask_n = dig_en;
            pend_flag_n = 1'b1;
        end
        if (state_n == ST_DRIVE) begin
            seg_n = act_seg_n[idx_n];
            sel_n = 4'b0001 << idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 16'd0;
            pend_seg   <= '{default: '0};
            act_seg    <= '{default: '0};
            pend_mask  <= 4'd0;
            act_mask   <= 4'd0;
            pend_flag  <= 1'b0;
            seg_out    <= 12'd0;
            dig_sel    <= 4'd0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            pend_seg   <= pend_seg_n;
            act_seg    <= act_seg_n;
            pend_mask  <= pend_mask_n;
            act_mask   <= act_mask_n;
            pend_flag  <= pend_flag_n;
            seg_out    <= seg_n;
            dig_sel    <= sel_n;
            frame_done <= frame_n;
            load_ack   <= ack_n;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: timeline-based reference model,
// directed scenarios plus randomized loads and enable toggles.
module tb_disp_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DIV + BLANK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] seg0 = '0, seg1 = '0, seg2 = '0, seg3 = '0;
    logic [3:0]  dig_en = '0;
    logic        load = 1'b0;
    logic [11:0] seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        load_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .dig_en(dig_en), .load(load),
        .seg_out(seg_out), .dig_sel(dig_sel),
        .frame_done(frame_done), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    // model: running flag, current digit, position inside the digit slot
    bit          m_run;
    int          m_dig;
    int          m_t;
    logic [11:0] aseg [4];
    logic [11:0] pseg [4];
    logic [3:0]  amask, pmask;
    bit          pflag, e_fd, e_la;

    function automatic int first_from(input logic [3:0] m, input int s);
        for (int i = s; i < 4; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_dig = 0; m_t = 0;
        aseg = '{default: '0}; pseg = '{default: '0};
        amask = 0; pmask = 0; pflag = 0; e_fd = 0; e_la = 0;
    endtask

    task automatic do_apply();
        aseg = pseg; amask = pmask; pflag = 0; e_la = 1;
    endtask

    task automatic model_step();
        int nd;
        e_fd = 0; e_la = 0;
        if (!m_run) begin
            if (pflag) do_apply();
            else if (enable && amask != 0) begin
                m_run = 1; m_dig = first_from(amask, 0); m_t = 0;
            end
        end else if (m_t < DIV) begin
            m_t = enable ? m_t + 1 : DIV;
        end else if (m_t < SLOT - 1) begin
            m_t++;
        end else begin
            m_t = 0;
            if (!enable) begin
                m_run = 0; m_dig = 0;
            end else begin
                nd = first_from(amask, m_dig + 1);
                if (nd < 0) begin
                    e_fd = 1;
                    if (pflag) do_apply();
                    if (amask == 0) m_run = 0;
                    nd = first_from(amask, 0);
                    if (nd < 0) nd = 0;
                end
                m_dig = nd;
            end
        end
        if (load) begin
            pseg = '{seg0, seg1, seg2, seg3};
            pmask = dig_en; pflag = 1;
        end
    endtask

    function automatic logic [17:0] expv();
        logic [3:0] one;
        one = 4'b0001 << m_dig;
        if (m_run && m_t < DIV) return {aseg[m_dig], one, e_fd, e_la};
        return {16'd0, e_fd, e_la};
    endfunction

    function automatic logic [17:0] obs();
        return {seg_out, dig_sel, frame_done, load_ack};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
    endtask

    task automatic set_segs(input logic [11:0] a, b, c, d,
                            input logic [3:0] m);
        seg0 = a; seg1 = b; seg2 = c; seg3 = d; dig_en = m; load = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        enable = 1'b1;
        set_segs(12'h111, 12'h222, 12'h333, 12'h444, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", obs());
        end
        load = 1'b0; enable = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_basic();
        int last_fd = -1;
        set_segs(12'h001, 12'h002, 12'h004, 12'h008, 4'b1111);
        for (int i = 0; i < 80; i++) begin
            if (i == 2) enable = 1'b1;
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (i == 1) begin
                checks++;
                if (load_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_ack got=%b exp=1", load_ack);
                end
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != 4 * SLOT) begin
                        errors++;
                        $display("FAIL basic_period got=%0d exp=%0d", cyc - last_fd, 4 * SLOT);
                    end
                end
                last_fd = cyc;
            end
        end
    endtask

    task automatic test_mask();
        int last_fd = -1;
        set_segs(12'h001, 12'h002, 12'h004, 12'h008, 4'b1010);
        for (int i = 0; i < 60; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL mask cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != 2 * SLOT) begin
                        errors++;
                        $display("FAIL mask_period got=%0d exp=%0d", cyc - last_fd, 2 * SLOT);
                    end
                end
                last_fd = cyc;
            end
        end
    endtask

    task automatic test_load_mid();
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL loadmid_wait cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (dig_sel == 4'b0010) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL loadmid_timeout got=%b exp=0010", dig_sel);
        end
        set_segs(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'b1111);
        for (int i = 0; i < 40; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL loadmid cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (load_ack === 1'b1) begin
                checks++;
                if ({frame_done, seg_out, dig_sel} !== {1'b1, 12'hFFF, 4'b0001}) begin
                    errors++;
                    $display("FAIL loadmid_apply got=%b/%h/%b exp=1/fff/0001",
                             frame_done, seg_out, dig_sel);
                end
            end
        end
    endtask

    task automatic test_disable();
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL dis_wait cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (dig_sel == 4'b0100) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL dis_timeout got=%b exp=0100", dig_sel);
        end
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 8) enable = 1'b1;
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL disable cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (i == 4) begin
                checks++;
                if (obs() !== 18'd0) begin
                    errors++;
                    $display("FAIL dis_idle got=%h exp=0", obs());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rstmid_wait cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (dig_sel != 4'b0000) hit = 1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_out, dig_sel, frame_done, load_ack} !== 18'd0 || !hit) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=0 hit=%0d", obs(), hit);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(); checks++;
            if (obs() !== expv() || obs() !== 18'd0) begin
                errors++;
                $display("FAIL rstmid_idle cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_zero_mask();
        bit seen = 0;
        set_segs(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 4'b1111);
        for (int i = 0; i < 30; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL zero_pre cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
        end
        set_segs(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            if (frame_done === 1'b1 && load_ack === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || obs() !== 18'd0) begin
            errors++;
            $display("FAIL zero_final got=%h seen=%0d exp=0 seen=1", obs(), seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0)
                set_segs(12'($urandom), 12'($urandom), 12'($urandom),
                         12'($urandom), 4'($urandom_range(15)));
            if ($urandom_range(39) == 0) enable = ~enable;
            tick(); checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_mask();
        test_load_mid();
        test_disable();
        test_reset_mid();
        test_zero_mask();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
